i2c_bus_arbiter: RTL and testbench

Shares one I2C byte engine (send/datasend/sended, receive/datareceive/received handshake) among NUM_REQ client blocks. Round-robin grant per transaction. The grant is held across multi-byte transfers until the client drops its request. A watchdog reclaims the bus from a stalled client. Sits between client FSMs (sensor pollers, config loaders) and the single I2C engine instance.

---
 rtl/i2c_bus_arbiter_pkg.sv | 11 +
 rtl/i2c_rr_pick.sv | 43 ++++
 rtl/i2c_bus_arbiter.sv | 136 +++++++++++++
 tb/tb_i2c_bus_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_bus_arbiter_pkg.sv
// Shared definitions for the I2C byte-engine arbiter.
package i2c_bus_arbiter_pkg;

  // Arbiter FSM encodings.
  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT   = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/i2c_rr_pick.sv
// Combinational round-robin picker: first set bit of vector searching
// upward from pointer+1, wrapping modulo NUM_REQ.
module i2c_rr_pick
  import i2c_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic [NUM_REQ-1:0] vector,
  input  logic [IDW-1:0]     pointer,
  output logic               found,
  output logic [IDW-1:0]     idx
);

  localparam int SW = IDW + 1;

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [SW-1:0]        start;
  logic [SW-1:0]        off;
  logic [SW-1:0]        sum;

  // Rotate so that bit 0 of rot is the highest-priority candidate.
  assign dbl   = {vector, vector};
  assign start = {1'b0, pointer} + 1'b1;
  assign rot   = NUM_REQ'(dbl >> start);

  // Lowest set bit of the rotated vector, mapped back to a client index.
  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (rot[j]) begin
        found = 1'b1;
        off   = SW'(j);
      end
    end
    sum = start + off;
    if (sum >= SW'(NUM_REQ)) sum = sum - SW'(NUM_REQ);
    idx = sum[IDW-1:0];
  end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one I2C byte engine among NUM_REQ clients,
// with a watchdog that reclaims the bus from a stalled client.
module i2c_bus_arbiter
  import i2c_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int IDW            = 2,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNTW           = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  output logic [NUM_REQ-1:0]   gnt,
  input  logic [NUM_REQ-1:0]   send,
  input  logic [8*NUM_REQ-1:0] datasend,
  output logic [NUM_REQ-1:0]   sended,
  input  logic [NUM_REQ-1:0]   receive,
  output logic [7:0]           datareceive,
  output logic [NUM_REQ-1:0]   received,
  output logic                 eng_send,
  output logic [7:0]           eng_datasend,
  input  logic                 eng_sended,
  output logic                 eng_receive,
  input  logic [7:0]           eng_datareceive,
  input  logic                 eng_received,
  input  logic                 eng_busy,
  output logic                 timeout,
  output logic [IDW-1:0]       timeout_id
);

  arb_state_t          state, state_nxt;
  logic [NUM_REQ-1:0]  gnt_nxt;
  logic [NUM_REQ-1:0]  mask, mask_nxt;
  logic [IDW-1:0]      idx, idx_nxt;
  logic [IDW-1:0]      ptr, ptr_nxt;
  logic [IDW-1:0]      tid_nxt;
  logic [IDW-1:0]      pick_idx;
  logic                pick_found;
  logic [CNTW-1:0]     cnt, cnt_nxt;
  logic                timeout_nxt;
  logic                granted;

  i2c_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_pick (
    .vector  (req & ~mask),
    .pointer (ptr),
    .found   (pick_found),
    .idx     (pick_idx)
  );

  // Engine/client routing; gnt is zero outside GRANT so strobes stay local.
  assign granted      = (state == ARB_GRANT);
  assign eng_send     = granted & send[idx];
  assign eng_receive  = granted & receive[idx];
  assign eng_datasend = datasend[{idx, 3'b000} +: 8];
  assign sended       = gnt & {NUM_REQ{eng_sended}};
  assign received     = gnt & {NUM_REQ{eng_received}};
  assign datareceive  = eng_datareceive;

  // Next-state, grant, watchdog and mask logic.
  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt;
    idx_nxt     = idx;
    ptr_nxt     = ptr;
    cnt_nxt     = cnt;
    mask_nxt    = mask & req;
    timeout_nxt = 1'b0;
    tid_nxt     = timeout_id;
    case (state)
      ARB_IDLE: begin
        cnt_nxt = '0;
        if (pick_found && !eng_busy) begin
          gnt_nxt   = NUM_REQ'(1'b1) << pick_idx;
          idx_nxt   = pick_idx;
          state_nxt = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (!req[idx]) begin
          gnt_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = ARB_RELEASE;
        end else if (eng_sended || eng_received) begin
          cnt_nxt = '0;
        end else if (cnt == CNTW'(TIMEOUT_CYCLES - 1)) begin
          timeout_nxt   = 1'b1;
          tid_nxt       = idx;
          mask_nxt[idx] = 1'b1;
          gnt_nxt       = '0;
          cnt_nxt       = '0;
          state_nxt     = ARB_RELEASE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ARB_RELEASE: begin
        if (!eng_busy) begin
          ptr_nxt   = idx;
          state_nxt = ARB_IDLE;
        end
      end
      default: begin
        gnt_nxt   = '0;
        state_nxt = ARB_IDLE;
      end
    endcase
  end

  // State and control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ARB_IDLE;
      gnt        <= '0;
      idx        <= '0;
      ptr        <= IDW'(NUM_REQ - 1);
      cnt        <= '0;
      mask       <= '0;
      timeout    <= 1'b0;
      timeout_id <= '0;
    end else begin
      state      <= state_nxt;
      gnt        <= gnt_nxt;
      idx        <= idx_nxt;
      ptr        <= ptr_nxt;
      cnt        <= cnt_nxt;
      mask       <= mask_nxt;
      timeout    <= timeout_nxt;
      timeout_id <= tid_nxt;
    end
  end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Self-checking bench for i2c_bus_arbiter: directed scenarios plus a
// randomized run, all compared each cycle against a behavioural model.
module tb_i2c_bus_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int TO  = 16;
  localparam int CW  = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req, send, receive;
  logic [8*N-1:0] datasend;
  logic           eng_sended, eng_received, eng_busy;
  logic [7:0]     eng_datareceive;
  logic [N-1:0]   gnt, sended, received;
  logic [7:0]     datareceive, eng_datasend;
  logic           eng_send, eng_receive, timeout;
  logic [IDW-1:0] timeout_id;

  i2c_bus_arbiter #(
    .NUM_REQ(N), .IDW(IDW), .TIMEOUT_CYCLES(TO), .CNTW(CW)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .gnt(gnt),
    .send(send), .datasend(datasend), .sended(sended),
    .receive(receive), .datareceive(datareceive), .received(received),
    .eng_send(eng_send), .eng_datasend(eng_datasend), .eng_sended(eng_sended),
    .eng_receive(eng_receive), .eng_datareceive(eng_datareceive),
    .eng_received(eng_received), .eng_busy(eng_busy),
    .timeout(timeout), .timeout_id(timeout_id)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: who owns the bus, whether it is draining, who was
  // served last, idle-cycle count of the owner, and blocked clients.
  int         m_owner = -1;
  int         m_last  = N - 1;
  int         m_wd    = 0;
  int         m_tid   = 0;
  bit         m_drain = 1'b0;
  bit         m_to    = 1'b0;
  bit         m_valid = 1'b0;
  bit [N-1:0] m_blk   = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_check();
    logic [N-1:0] g;
    bit           own;
    if (m_valid) begin
      g   = '0;
      own = (m_owner >= 0) && !m_drain;
      if (own) g[m_owner] = 1'b1;
      chk("gnt", 32'(gnt), 32'(g));
      chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      chk("timeout", 32'(timeout), 32'(m_to));
      chk("timeout_id", 32'(timeout_id), 32'(m_tid));
      chk("datareceive", 32'(datareceive), 32'(eng_datareceive));
      chk("sended", 32'(sended), 32'(eng_sended ? g : '0));
      chk("received", 32'(received), 32'(eng_received ? g : '0));
      if (own) begin
        chk("eng_send", 32'(eng_send), 32'(send[m_owner]));
        chk("eng_receive", 32'(eng_receive), 32'(receive[m_owner]));
        chk("eng_datasend", 32'(eng_datasend), 32'(datasend[m_owner*8 +: 8]));
      end else begin
        chk("eng_send_idle", 32'(eng_send), 32'd0);
        chk("eng_receive_idle", 32'(eng_receive), 32'd0);
      end
    end
  endtask

  task automatic model_step();
    bit [N-1:0] blk0;
    if (reset) begin
      m_owner = -1; m_last = N - 1; m_wd = 0; m_tid = 0;
      m_drain = 0;  m_to = 0;       m_blk = '0; m_valid = 1;
      return;
    end
    m_to  = 0;
    blk0  = m_blk;
    m_blk = m_blk & req;
    if (m_owner < 0) begin
      if (!eng_busy) begin
        for (int k = 1; k <= N; k++) begin
          automatic int c = (m_last + k) % N;
          if (req[c] && !blk0[c]) begin
            m_owner = c; m_drain = 0; m_wd = 0;
            break;
          end
        end
      end
    end else if (!m_drain) begin
      if (!req[m_owner]) m_drain = 1;
      else if (eng_sended || eng_received) m_wd = 0;
      else if (m_wd == TO - 1) begin
        m_to = 1; m_tid = m_owner; m_blk[m_owner] = 1'b1; m_drain = 1;
      end else m_wd++;
    end else if (!eng_busy) begin
      m_last = m_owner; m_owner = -1; m_drain = 0;
    end
  endtask

  // One clock: compare at the falling edge, advance the model, then
  // return just after the rising edge so inputs can change safely.
  task automatic tick();
    @(negedge clk);
    model_check();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); reset = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    reset = 1'b1; req = '0; send = '0; receive = '0; datasend = '0;
    eng_sended = 0; eng_received = 0; eng_busy = 0; eng_datareceive = 8'h00;
    tick(); tick();
    reset = 1'b0;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_timeout_id", 32'(timeout_id), 32'd0);
    chk("rst_eng_send", 32'(eng_send), 32'd0);

    // Single request and one byte.
    req = 4'b0001; tick();
    chk("t1_gnt", 32'(gnt), 32'h1);
    send = 4'b0001; datasend[7:0] = 8'hA0; #1;
    chk("t1_eng_send", 32'(eng_send), 32'd1);
    chk("t1_eng_datasend", 32'(eng_datasend), 32'hA0);
    eng_sended = 1'b1; #1;
    chk("t1_sended", 32'(sended), 32'h1);
    tick();
    eng_sended = 0; send = '0; req = '0; eng_busy = 1'b1; tick();
    chk("t1_drop_gnt", 32'(gnt), 32'd0);
    tick(); eng_busy = 1'b0; tick(); tick();

    // Round robin with all clients requesting.
    do_reset();
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      automatic int w = 0;
      while (gnt == '0 && w < 20) begin tick(); w++; end
      chk("t2_order", 32'(gnt), 32'(4'b0001 << (g % 4)));
      eng_sended = 1'b1; tick(); eng_sended = 0; tick();
      eng_received = 1'b1; eng_datareceive = 8'h3C; tick(); eng_received = 0;
      req[g % 4] = 1'b0; tick(); req = 4'b1111;
    end
    req = '0; tick(); tick(); tick();

    // Isolation of non-granted clients.
    do_reset();
    req = 4'b0100; tick();
    chk("t3_gnt", 32'(gnt), 32'h4);
    req = 4'b0111;
    datasend = {8'h00, 8'h5A, 8'hFF, 8'hFF};
    for (int i = 0; i < 12; i++) begin
      r = $urandom;
      send = {1'b0, 1'b1, r[1:0]}; receive = {1'b0, r[2], r[4:3]};
      eng_sended = r[5]; eng_received = r[6]; #1;
      chk("t3_eng_datasend", 32'(eng_datasend), 32'h5A);
      chk("t3_sended_others", 32'(sended & 4'b1011), 32'd0);
      chk("t3_received_others", 32'(received & 4'b1011), 32'd0);
      tick();
    end
    send = '0; receive = '0; eng_sended = 0; eng_received = 0; req = '0;
    tick(); tick(); tick();

    // Watchdog release, masking and re-eligibility.
    do_reset();
    req = 4'b0010; tick();
    chk("t4_gnt", 32'(gnt), 32'h2);
    req = 4'b1010;
    for (int c = 1; c <= 15; c++) tick();
    chk("t4_pre_gnt", 32'(gnt), 32'h2);
    chk("t4_pre_timeout", 32'(timeout), 32'd0);
    tick();
    chk("t4_timeout", 32'(timeout), 32'd1);
    chk("t4_timeout_id", 32'(timeout_id), 32'd1);
    chk("t4_gnt_off", 32'(gnt), 32'd0);
    tick();
    chk("t4_timeout_pulse", 32'(timeout), 32'd0);
    tick();
    chk("t4_next_client", 32'(gnt), 32'h8);
    req = 4'b0010; tick(); tick(); tick(); tick();
    chk("t4_masked", 32'(gnt), 32'd0);
    chk("t4_id_held", 32'(timeout_id), 32'd1);
    req = 4'b0000; tick();
    req = 4'b0010; tick();
    chk("t4_regrant", 32'(gnt), 32'h2);
    req = '0; tick(); tick(); tick();

    // Busy hold-off.
    do_reset();
    eng_busy = 1'b1; req = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_hold", 32'(gnt), 32'd0);
    end
    eng_busy = 1'b0; tick();
    chk("t5_gnt", 32'(gnt), 32'h4);

    // Reset in the middle of a granted byte.
    send = 4'b0100; tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("t6_gnt", 32'(gnt), 32'd0);
    chk("t6_eng_send", 32'(eng_send), 32'd0);
    chk("t6_timeout", 32'(timeout), 32'd0);
    send = '0; req = 4'b1111; tick();
    chk("t6_first", 32'(gnt), 32'h1);

    // Randomized traffic; strobe-free windows exercise the watchdog.
    do_reset();
    req = '0;
    for (int cyc = 0; cyc < 1200; cyc++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
      send = N'($urandom); receive = N'($urandom); datasend = $urandom;
      eng_datareceive = 8'($urandom);
      if (((cyc / 100) % 2) == 0) begin
        eng_sended = ($urandom_range(0, 3) == 0);
        eng_received = ($urandom_range(0, 3) == 0);
      end else begin
        eng_sended = 0; eng_received = 0;
      end
      eng_busy = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
